// File: rtl/cache_pkg.sv
// Shared dcache constants and the write-back drain FSM encoding.
package cache_pkg;

    localparam int CACHELINE_WD = 512;
    localparam int OFF_WD       = $clog2(CACHELINE_WD / 8);
    localparam int TAG_LSB      = OFF_WD;
    localparam int TAG_WD       = 32 - TAG_LSB;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/wbuf_match.sv
// DEPTH-way tag comparator; reports the youngest matching entry (closest to tail).
module wbuf_match #(
    parameter int DEPTH  = 4,
    parameter int TAG_WD = cache_pkg::TAG_WD,
    parameter int PTR_WD = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][TAG_WD-1:0] i_tags,
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [TAG_WD-1:0]            i_key,
    input  logic [PTR_WD-1:0]            i_tail,
    output logic                         o_hit,
    output logic [PTR_WD-1:0]            o_idx
);

    logic [DEPTH-1:0]  w_match;
    logic [PTR_WD-1:0] w_idx;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_cmp
            assign w_match[g] = i_valid[g] && (i_tags[g] == i_key);
        end
    endgenerate

    // Walk oldest to youngest so the slot just behind tail is the last to win.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PTR_WD'(k);
            if (w_match[w_idx]) begin
                o_hit = 1'b1;
                o_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/dcache_wbuf.sv
// Write-back buffer: queues dirty dcache victims and drains them one at a time to AXI.
// Optional in-place merge of re-evicted lines is enabled by defining WBUF_MERGE_EN.
module dcache_wbuf
    import cache_pkg::*;
#(
    parameter int CACHELINE_WD = cache_pkg::CACHELINE_WD,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [31:0]             push_addr,
    input  logic [CACHELINE_WD-1:0] push_line,
    input  logic [31:0]             lookup_addr,
    output logic                    lookup_hit,
    output logic [CACHELINE_WD-1:0] lookup_line,
    output logic                    axi_we,
    output logic [31:0]             axi_waddr,
    output logic [CACHELINE_WD-1:0] axi_cacheline_old,
    input  logic                    axi_wdone,
    output logic                    wbuf_empty,
    output logic                    wbuf_full
);

    localparam int OFF_W  = $clog2(CACHELINE_WD / 8);
    localparam int TAG_W  = 32 - OFF_W;
    localparam int PTR_WD = $clog2(DEPTH);

    logic [DEPTH-1:0][TAG_W-1:0]        r_tag;
    logic [DEPTH-1:0][CACHELINE_WD-1:0] r_line;
    logic [DEPTH-1:0]                   r_valid;
    logic [PTR_WD:0]                    r_head;
    logic [PTR_WD:0]                    r_tail;
    drain_state_e                       r_state;
    drain_state_e                       w_state_nxt;

    logic [PTR_WD-1:0] w_head_idx;
    logic [PTR_WD-1:0] w_tail_idx;
    logic [PTR_WD-1:0] w_lk_idx;
    logic              w_lk_hit;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_alloc;
    logic              w_unused;

    assign w_head_idx = r_head[PTR_WD-1:0];
    assign w_tail_idx = r_tail[PTR_WD-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[PTR_WD] != r_tail[PTR_WD]);
    assign w_pop      = (r_state == DRAIN_REQ) && axi_wdone;
    assign w_unused   = ^{push_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};

`ifdef WBUF_MERGE_EN
    logic [DEPTH-1:0]  w_merge_valid;
    logic [PTR_WD-1:0] w_merge_idx;
    logic              w_merge_hit;
    logic              w_merge;

    // The head is frozen while its write is in flight, so it is never a merge target.
    always_comb begin
        w_merge_valid = r_valid;
        if (r_state == DRAIN_REQ) w_merge_valid[w_head_idx] = 1'b0;
    end

    wbuf_match #(.DEPTH(DEPTH), .TAG_WD(TAG_W), .PTR_WD(PTR_WD)) u_merge (
        .i_tags  (r_tag),
        .i_valid (w_merge_valid),
        .i_key   (push_addr[31:OFF_W]),
        .i_tail  (w_tail_idx),
        .o_hit   (w_merge_hit),
        .o_idx   (w_merge_idx)
    );

    assign push_ready = !w_full || w_merge_hit;
    assign w_merge    = push_valid && w_merge_hit;
    assign w_alloc    = push_valid && !w_full && !w_merge_hit;
`else
    assign push_ready = !w_full;
    assign w_alloc    = push_valid && !w_full;
`endif

    wbuf_match #(.DEPTH(DEPTH), .TAG_WD(TAG_W), .PTR_WD(PTR_WD)) u_lookup (
        .i_tags  (r_tag),
        .i_valid (r_valid),
        .i_key   (lookup_addr[31:OFF_W]),
        .i_tail  (w_tail_idx),
        .o_hit   (w_lk_hit),
        .o_idx   (w_lk_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DRAIN_IDLE: if (!w_empty) w_state_nxt = DRAIN_REQ;
            DRAIN_REQ:  if (axi_wdone) w_state_nxt = DRAIN_IDLE;
            default:    w_state_nxt = DRAIN_IDLE;
        endcase
    end

    // Alloc and pop never target the same slot: that would need full and empty at once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_state <= DRAIN_IDLE;
        end else begin
            r_state <= w_state_nxt;
            if (w_alloc) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_tail              <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; every read is qualified by a valid bit or by REQ.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_tail_idx]  <= push_addr[31:OFF_W];
            r_line[w_tail_idx] <= push_line;
        end
`ifdef WBUF_MERGE_EN
        else if (w_merge) begin
            r_line[w_merge_idx] <= push_line;
        end
`endif
    end

    assign axi_we            = (r_state == DRAIN_REQ);
    assign axi_waddr         = axi_we ? {r_tag[w_head_idx], {OFF_W{1'b0}}} : 32'h0;
    assign axi_cacheline_old = axi_we ? r_line[w_head_idx] : '0;
    assign lookup_hit        = w_lk_hit;
    assign lookup_line       = w_lk_hit ? r_line[w_lk_idx] : '0;
    assign wbuf_empty        = w_empty;
    assign wbuf_full         = w_full;

endmodule

// File: tb/tb_dcache_wbuf.sv
// Randomised and directed bench for dcache_wbuf against a queue-based reference model.
module tb_dcache_wbuf;
    import cache_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = CACHELINE_WD;
`ifdef WBUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [31:0]   push_addr = '0;
    logic [LW-1:0] push_line = '0;
    logic [31:0]   lookup_addr = '0;
    logic          lookup_hit;
    logic [LW-1:0] lookup_line;
    logic          axi_we;
    logic [31:0]   axi_waddr;
    logic [LW-1:0] axi_cacheline_old;
    logic          axi_wdone = 1'b0;
    logic          wbuf_empty;
    logic          wbuf_full;

    always #5 clk = ~clk;

    dcache_wbuf #(.CACHELINE_WD(LW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .push_valid        (push_valid),
        .push_ready        (push_ready),
        .push_addr         (push_addr),
        .push_line         (push_line),
        .lookup_addr       (lookup_addr),
        .lookup_hit        (lookup_hit),
        .lookup_line       (lookup_line),
        .axi_we            (axi_we),
        .axi_waddr         (axi_waddr),
        .axi_cacheline_old (axi_cacheline_old),
        .axi_wdone         (axi_wdone),
        .wbuf_empty        (wbuf_empty),
        .wbuf_full         (wbuf_full)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chkb(input string name, input logic a, input logic e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b", name, a, e);
        end
    endtask

    task automatic chka(input string name, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, a, e);
        end
    endtask

    task automatic chkl(input string name, input logic [LW-1:0] a, input logic [LW-1:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, a, e);
        end
    endtask

    // ---------------- reference model: a plain queue of {addr, line} ----------------
    typedef struct {
        logic [31:0]   addr;
        logic [LW-1:0] line;
    } ent_t;

    ent_t q[$];
    bit   busy = 1'b0;   // a write for q[0] is being offered to AXI
    ent_t m_new;

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:OFF_WD] == b[31:OFF_WD];
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (same_line(q[i].addr, a)) return i;
        return -1;
    endfunction

    function automatic int m_merge_idx(input logic [31:0] a);
        if (!MERGE) return -1;
        for (int i = q.size() - 1; i >= 0; i--)
            if (same_line(q[i].addr, a) && !(i == 0 && busy)) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            q.delete();
            busy = 1'b0;
        end else begin
            automatic int sz  = q.size();
            automatic int mi  = m_merge_idx(push_addr);
            automatic bit acc = push_valid && (sz < DEPTH || mi >= 0);
            automatic bit pop = busy && axi_wdone;
            busy = busy ? !axi_wdone : (sz != 0);
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (mi >= 0) begin
                    q[pop ? mi - 1 : mi].line = push_line;
                end else begin
                    m_new.addr = push_addr;
                    m_new.line = push_line;
                    q.push_back(m_new);
                end
            end
        end
    end

    // Completed writes as seen on the DUT interface, for order checks.
    logic [31:0]   dut_wr[$];
    logic [LW-1:0] dut_wl[$];

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int li = m_lookup(lookup_addr);
            automatic int mi = m_merge_idx(push_addr);
            chkb("empty", wbuf_empty, q.size() == 0);
            chkb("full", wbuf_full, q.size() == DEPTH);
            chkb("push_ready", push_ready, (q.size() < DEPTH) || (mi >= 0));
            chkb("axi_we", axi_we, busy);
            if (busy) begin
                chka("axi_waddr", axi_waddr, {q[0].addr[31:OFF_WD], {OFF_WD{1'b0}}});
                chkl("axi_line", axi_cacheline_old, q[0].line);
            end
            chkb("lookup_hit", lookup_hit, li >= 0);
            if (li >= 0) chkl("lookup_line", lookup_line, q[li].line);
            if (axi_we && axi_wdone) begin
                dut_wr.push_back(axi_waddr);
                dut_wl.push_back(axi_cacheline_old);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [LW-1:0] pat(input logic [31:0] s);
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = s ^ i;
        return v;
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [LW-1:0] d);
        bit ok = 1'b0;
        push_valid = 1'b1;
        push_addr  = a;
        push_line  = d;
        for (int c = 0; c < 64 && !ok; c++) begin
            ok = push_ready;
            tick();
        end
        push_valid = 1'b0;
        chkb("push_accepted", ok, 1'b1);
    endtask

    task automatic drain_all();
        for (int c = 0; c < 300 && !wbuf_empty; c++) begin
            if (axi_we) begin
                axi_wdone = 1'b1;
                tick();
                axi_wdone = 1'b0;
            end else begin
                tick();
            end
        end
        chkb("drain_done", wbuf_empty, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        resetn = 1'b1;
        chk_en = 1'b1;
        chkb("rst_empty", wbuf_empty, 1'b1);
        chkb("rst_full", wbuf_full, 1'b0);
        chkb("rst_we", axi_we, 1'b0);
        chkb("rst_ready", push_ready, 1'b1);

        // single line: request one cycle after the push, held until wdone
        do_push(32'h1000_0040, pat(32'hA5A5_0000));
        chkb("t1_we_early", axi_we, 1'b0);
        tick();
        chkb("t1_we", axi_we, 1'b1);
        chka("t1_addr", axi_waddr, 32'h1000_0040);
        for (int i = 0; i < 10; i++) begin
            tick();
            chkb("t1_hold_we", axi_we, 1'b1);
            chka("t1_hold_addr", axi_waddr, 32'h1000_0040);
            chkl("t1_hold_line", axi_cacheline_old, pat(32'hA5A5_0000));
        end
        axi_wdone = 1'b1;
        tick();
        axi_wdone = 1'b0;
        chkb("t1_we_off", axi_we, 1'b0);
        chkb("t1_empty", wbuf_empty, 1'b1);

        // fill, stall a fifth push, push rejected in the wdone cycle, then drain order
        dut_wr.delete(); dut_wl.delete();
        do_push(32'h100, pat(32'h100));
        do_push(32'h140, pat(32'h140));
        do_push(32'h180, pat(32'h180));
        do_push(32'h1C0, pat(32'h1C0));
        chkb("t2_full", wbuf_full, 1'b1);
        chkb("t2_ready", push_ready, 1'b0);
        push_valid = 1'b1; push_addr = 32'h200; push_line = pat(32'h200);
        repeat (3) tick();
        chkb("t2_stall_full", wbuf_full, 1'b1);
        axi_wdone = 1'b1;
        chkb("t2_ready_wdone", push_ready, 1'b0);
        tick();
        axi_wdone = 1'b0;
        chkb("t2_after_pop_full", wbuf_full, 1'b0);
        chkb("t2_after_pop_ready", push_ready, 1'b1);
        tick();
        push_valid = 1'b0;
        chkb("t2_refull", wbuf_full, 1'b1);
        drain_all();
        chka("t2_nwr", dut_wr.size(), 5);
        if (dut_wr.size() == 5) begin
            chka("t2_ord0", dut_wr[0], 32'h100);
            chka("t2_ord1", dut_wr[1], 32'h140);
            chka("t2_ord2", dut_wr[2], 32'h180);
            chka("t2_ord3", dut_wr[3], 32'h1C0);
            chka("t2_ord4", dut_wr[4], 32'h200);
            chkl("t2_line4", dut_wl[4], pat(32'h200));
        end

        // lookup of a queued line
        do_push(32'h2000, pat(32'h2222));
        lookup_addr = 32'h2024;
        #1;
        chkb("t3_hit", lookup_hit, 1'b1);
        chkl("t3_line", lookup_line, pat(32'h2222));
        drain_all();
        #1;
        chkb("t3_miss", lookup_hit, 1'b0);

        // duplicate line address queued behind a busy head
        dut_wr.delete(); dut_wl.delete();
        do_push(32'h4000, pat(32'h4444));
        tick();
        do_push(32'h3000, pat(32'hBBBB));
        do_push(32'h3000, pat(32'hCCCC));
        lookup_addr = 32'h3010;
        #1;
        chkb("t4_hit", lookup_hit, 1'b1);
        chkl("t4_line", lookup_line, pat(32'hCCCC));
        drain_all();
`ifdef WBUF_MERGE_EN
        chka("t4_nwr", dut_wr.size(), 2);
        if (dut_wr.size() == 2) begin
            chka("t4_addr1", dut_wr[1], 32'h3000);
            chkl("t4_line1", dut_wl[1], pat(32'hCCCC));
        end
`else
        chka("t4_nwr", dut_wr.size(), 3);
        if (dut_wr.size() == 3) begin
            chkl("t4_line1", dut_wl[1], pat(32'hBBBB));
            chkl("t4_line2", dut_wl[2], pat(32'hCCCC));
        end
`endif

        // reset in the middle of a request, then a stray wdone
        dut_wr.delete(); dut_wl.delete();
        do_push(32'h5000, pat(32'h5555));
        tick();
        chkb("t5_we", axi_we, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chkb("t5_we_rst", axi_we, 1'b0);
        chkb("t5_empty_rst", wbuf_empty, 1'b1);
        axi_wdone = 1'b1;
        tick();
        axi_wdone = 1'b0;
        chkb("t5_stray_empty", wbuf_empty, 1'b1);
        chka("t5_nwr", dut_wr.size(), 0);
        do_push(32'h6000, pat(32'h6666));
        drain_all();
        chka("t5_nwr2", dut_wr.size(), 1);
        if (dut_wr.size() == 1) chka("t5_addr", dut_wr[0], 32'h6000);

        // random traffic over a small set of lines so duplicates and wraps are common
        for (int i = 0; i < 800; i++) begin
            push_valid  = ($urandom % 2) == 0;
            push_addr   = 32'h0008_0000 + ($urandom % 8) * 64 + ($urandom % 64);
            push_line   = rnd_line();
            lookup_addr = 32'h0008_0000 + ($urandom % 8) * 64 + ($urandom % 64);
            axi_wdone   = axi_we ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
            resetn      = ($urandom % 150) != 0;
            tick();
        end
        resetn = 1'b1;
        push_valid = 1'b0;
        axi_wdone = 1'b0;
        drain_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
